// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [5:0]       Funct,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_rem, r_quo, r_dvs, r_a;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_done, r_neg_q, r_neg_r, r_dz;
  logic               w_md, w_acc, w_mt, w_mul, w_div, w_sgn, w_ge;
  logic [2*WIDTH-1:0] w_ax, w_bx, w_prod;
  logic [WIDTH-1:0]   w_amag, w_bmag, w_rem_n, w_q_fix, w_r_fix;
  logic [WIDTH:0]     w_sh;
  // The eight muldiv codes are exactly 01x0xx.
  assign w_md  = (Funct[5:4] == 2'b01) && !Funct[2];
  assign w_acc = req && !flush && !busy && w_md;
  assign w_mt  = !Funct[3] && Funct[0];
  assign w_mul = Funct[3] && !Funct[1];
  assign w_div = Funct[3] && Funct[1];
  assign w_sgn = ~Funct[0];
  assign w_ax   = {{WIDTH{w_sgn & a[WIDTH-1]}}, a};
  assign w_bx   = {{WIDTH{w_sgn & b[WIDTH-1]}}, b};
  assign w_prod = w_ax * w_bx;
  assign w_amag = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_bmag = (w_sgn && b[WIDTH-1]) ? -b : b;
  // One restoring step: shift the next dividend bit in, subtract if it fits.
  assign w_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = w_sh >= {1'b0, r_dvs};
  assign w_rem_n = w_ge ? (w_sh[WIDTH-1:0] - r_dvs) : w_sh[WIDTH-1:0];
  assign w_q_fix = r_dz ? '1  : (r_neg_q ? -r_quo : r_quo);
  assign w_r_fix = r_dz ? r_a : (r_neg_r ? -r_rem : r_rem);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !w_acc ? S_IDLE : w_mul ? S_MUL : w_div ? S_DIV : S_IDLE;
      S_MUL:   w_next = (r_cnt == '0) ? S_IDLE : S_MUL;
      S_DIV:   w_next = (r_cnt == '0) ? S_FIX : S_DIV;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    busy  = (r_state != S_IDLE);
    stall = req && !flush && busy && w_md;
    done  = r_done;
    hi    = r_hi;
    lo    = r_lo;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_acc && w_mt && Funct[1]) r_lo <= a;
      if (w_acc && w_mt && !Funct[1]) r_hi <= a;
      if (w_acc && w_mul) begin
        r_prod <= w_prod;
        r_cnt  <= CW'(MUL_CYCLES - 1);
      end
      if (w_acc && w_div) begin
        r_rem   <= '0;
        r_quo   <= w_amag;
        r_dvs   <= w_bmag;
        r_a     <= a;
        r_dz    <= (b == '0);
        r_neg_q <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r <= w_sgn && a[WIDTH-1];
        r_cnt   <= CW'(WIDTH - 1);
      end
      if (r_state == S_MUL) begin
        if (r_cnt == '0) begin
          {r_hi, r_lo} <= r_prod;
          r_done       <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
      if (r_state == S_DIV) begin
        r_rem <= w_rem_n;
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == S_FIX) begin
        r_lo   <= w_q_fix;
        r_hi   <= w_r_fix;
        r_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and hand-sequenced checks of muldiv_unit with a result scoreboard.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] ADD = 6'b100000;
  logic clk = 1'b0, reset = 1'b0, req = 1'b0, flush = 1'b0;
  logic [5:0] Funct = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] hi, lo;
  logic busy, stall, done;
  int checks = 0, failures = 0;
  logic [2*W-1:0] sb[$];
  typedef struct {
    string nm;
    logic [5:0] f;
    logic fl;
    logic [W-1:0] a, b, hi, lo;
    int cyc;
  } vec_t;
  vec_t tv[$];
  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req(req), .Funct(Funct), .flush(flush),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input string nm, input logic [5:0] f, input logic fl, input logic [W-1:0] ai,
                     input logic [W-1:0] bi, input logic [W-1:0] eh, input logic [W-1:0] el, input int cyc);
    vec_t v;
    v.nm = nm; v.f = f; v.fl = fl; v.a = ai; v.b = bi; v.hi = eh; v.lo = el; v.cyc = cyc;
    tv.push_back(v);
  endtask
  task automatic run_op(input vec_t v);
    int n = 0;
    logic [2*W-1:0] e;
    @(negedge clk);
    req = 1'b1; Funct = v.f; flush = v.fl; a = v.a; b = v.b;
    sb.push_back({v.hi, v.lo});
    @(negedge clk);
    req = 1'b0; flush = 1'b0; a = $urandom; b = $urandom;
    while (busy && n < 200) begin
      n++;
      flush = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    flush = 1'b0;
    chk({v.nm, " busy_cycles"}, 64'(n), 64'(v.cyc));
    chk({v.nm, " done"}, 64'(done), 64'(v.cyc > 0));
    e = sb.pop_front();
    chk({v.nm, " hi"}, 64'(hi), 64'(e[2*W-1:W]));
    chk({v.nm, " lo"}, 64'(lo), 64'(e[W-1:0]));
    @(negedge clk);
    chk({v.nm, " done_single"}, 64'(done), 64'(0));
  endtask
  initial begin
    int n, sbad;
    logic [2*W-1:0] e;
    add("mult_neg",   MULT,  1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 4);
    add("multu_big",  MULTU, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 4);
    add("div_m7_2",   DIV,   1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    add("divu_zero",  DIVU,  1'b0, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 33);
    add("div_ovf",    DIV,   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    add("divu_100_7", DIVU,  1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       33);
    add("div_7_m2",   DIV,   1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33);
    add("div_m7_m2",  DIV,   1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33);
    add("div_zero_s", DIV,   1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 33);
    add("divu_max_1", DIVU,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33);
    add("div_min_2",  DIV,   1'b0, 32'h80000000, 32'd2,        32'd0,        32'hC0000000, 33);
    add("multu_max",  MULTU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4);
    add("mult_min",   MULT,  1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 4);
    add("mult_m1",    MULT,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4);
    add("mthi",       MTHI,  1'b0, 32'hDEADBEEF, 32'd9,        32'hDEADBEEF, 32'h00000001, 0);
    add("mtlo",       MTLO,  1'b0, 32'h0BADF00D, 32'd9,        32'hDEADBEEF, 32'h0BADF00D, 0);
    add("non_md",     ADD,   1'b0, 32'd5,        32'd6,        32'hDEADBEEF, 32'h0BADF00D, 0);
    add("flushed",    MULT,  1'b1, 32'd2,        32'd3,        32'hDEADBEEF, 32'h0BADF00D, 0);
    add("mfhi",       MFHI,  1'b0, 32'd1,        32'd1,        32'hDEADBEEF, 32'h0BADF00D, 0);
    repeat (3) @(negedge clk);
    req = 1'b1; Funct = MULT; #1;
    chk("reset_hilo", {hi, lo}, 64'(0));
    chk("reset_flags", 64'({busy, done, stall}), 64'(0));
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    foreach (tv[i]) run_op(tv[i]);
    // DIVU in flight with dependent MFLO, then MTHI, held on req.
    @(negedge clk);
    req = 1'b1; Funct = DIVU; a = 32'd1000; b = 32'd3;
    sb.push_back({32'd1, 32'd333});
    @(negedge clk);
    Funct = MFLO; a = $urandom; b = $urandom; #1;
    n = 0; sbad = 0;
    repeat (5) begin
      if (!(stall && busy)) sbad++;
      n++;
      @(negedge clk);
    end
    Funct = MTHI; a = 32'hA5A5A5A5; #1;
    while (busy && n < 200) begin
      if (!stall) sbad++;
      n++;
      @(negedge clk);
    end
    chk("stall_busy_cycles", 64'(n), 64'(33));
    chk("stall_held", 64'(sbad), 64'(0));
    chk("stall_release", 64'(stall), 64'(0));
    chk("stall_done", 64'(done), 64'(1));
    e = sb.pop_front();
    chk("stall_quotient", 64'(lo), 64'(e[W-1:0]));
    chk("stall_remainder", 64'(hi), 64'(e[2*W-1:W]));
    @(negedge clk);
    req = 1'b0;
    chk("mthi_after_done", {hi, lo}, {32'hA5A5A5A5, 32'd333});
    chk("mthi_no_busy", 64'({busy, done}), 64'(0));
    // Back-to-back: second op accepted in the done cycle of the first.
    @(negedge clk);
    req = 1'b1; Funct = MULT; a = 32'd3; b = 32'd4;
    sb.push_back({32'd0, 32'd12});
    @(negedge clk);
    req = 1'b0; n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("b2b_first_cycles", 64'(n), 64'(4));
    chk("b2b_first_done", 64'(done), 64'(1));
    e = sb.pop_front();
    chk("b2b_first_result", {hi, lo}, e);
    req = 1'b1; Funct = MULTU; a = 32'd6; b = 32'd7;
    sb.push_back({32'd0, 32'd42});
    @(negedge clk);
    req = 1'b0; n = 0;
    chk("b2b_second_accept", 64'({busy, done}), 64'(2'b10));
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("b2b_second_cycles", 64'(n), 64'(4));
    e = sb.pop_front();
    chk("b2b_second_result", {hi, lo}, e);
    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    req = 1'b1; Funct = DIV; a = 32'hFFFFFF9C; b = 32'd3;
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'(0));
    chk("async_reset_flags", 64'({busy, done}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    run_op('{"post_reset_mult", MULT, 1'b0, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, 4});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
